// File: rtl/pc_unit.sv
// Fetch program counter: next-PC priority select with stall-time
// redirect buffering and misaligned-fetch flagging.
module pc_unit #(
   parameter int unsigned       WIDTH        = 32,
   parameter logic [WIDTH-1:0]  RESET_VECTOR = 32'hBFC0_0000,
   parameter logic [WIDTH-1:0]  EXC_VECTOR   = 32'hBFC0_0380,
   parameter int unsigned       INC          = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jmp,
   input  logic [WIDTH-1:0] jmp_target,
   input  logic             exc,
   input  logic             eret,
   input  logic [WIDTH-1:0] eret_target,
   output logic [WIDTH-1:0] pc,
   output logic             pc_valid,
   output logic             adel,
   output logic             pend
);

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_nxt;
   logic             r_pc_valid;
   logic             w_pc_valid_nxt;
   logic             r_adel;
   logic             w_adel_nxt;
   logic             r_pend;
   logic             w_pend_nxt;
   logic [WIDTH-1:0] r_pend_tgt;
   logic [WIDTH-1:0] w_pend_tgt_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= BOOT;
         r_pc       <= RESET_VECTOR;
         r_pc_valid <= 1'b0;
         r_adel     <= 1'b0;
         r_pend     <= 1'b0;
         r_pend_tgt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_pc_valid <= w_pc_valid_nxt;
         r_adel     <= w_adel_nxt;
         r_pend     <= w_pend_nxt;
         r_pend_tgt <= w_pend_tgt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_pc_valid_nxt = r_pc_valid;
      w_adel_nxt     = r_adel;
      w_pend_nxt     = r_pend;
      w_pend_tgt_nxt = r_pend_tgt;
      unique case (r_state)
         BOOT: begin
            w_state_nxt    = RUN;
            w_pc_valid_nxt = 1'b1;
         end
         RUN: begin
            w_pc_valid_nxt = 1'b1;
            if (exc) begin
               w_pc_nxt   = EXC_VECTOR;
               w_pend_nxt = 1'b0;
            end else if (eret) begin
               w_pc_nxt   = eret_target;
               w_pend_nxt = 1'b0;
            end else if (stall) begin
               // first redirect seen during a stall wins
               if (!r_pend && (br_taken || jmp)) begin
                  w_pend_nxt     = 1'b1;
                  w_pend_tgt_nxt = br_taken ? br_target : jmp_target;
               end
            end else if (r_pend) begin
               w_pc_nxt   = r_pend_tgt;
               w_pend_nxt = 1'b0;
            end else if (br_taken) begin
               w_pc_nxt = br_target;
            end else if (jmp) begin
               w_pc_nxt = jmp_target;
            end else begin
               w_pc_nxt = r_pc + INC_W;
            end
            w_adel_nxt = (w_pc_nxt[1:0] != 2'b00);
         end
         default: begin
            w_state_nxt = BOOT;
         end
      endcase
   end

   assign pc       = r_pc;
   assign pc_valid = r_pc_valid;
   assign adel     = r_adel;
   assign pend     = r_pend;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expected outputs are queued when a step
// is driven and popped for comparison after the clock edge.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp;
   logic [31:0] jmp_target;
   logic        exc;
   logic        eret;
   logic [31:0] eret_target;
   logic [31:0] pc;
   logic        pc_valid;
   logic        adel;
   logic        pend;

   typedef struct {
      logic [31:0] pc;
      logic        vld;
      logic        adel;
      logic        pend;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   pc_unit #(
      .WIDTH       (32),
      .RESET_VECTOR(32'hBFC0_0000),
      .EXC_VECTOR  (32'hBFC0_0380),
      .INC         (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .exc        (exc),
      .eret       (eret),
      .eret_target(eret_target),
      .pc         (pc),
      .pc_valid   (pc_valid),
      .adel       (adel),
      .pend       (pend)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic expect_out(input logic [31:0] e_pc, input logic e_v,
                             input logic e_a, input logic e_p,
                             input string tag);
      exp_t e;
      e.pc   = e_pc;
      e.vld  = e_v;
      e.adel = e_a;
      e.pend = e_p;
      e.tag  = tag;
      q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      total++;
      assert (q.size() != 0) else begin
         bad++;
         $error("FAIL scoreboard empty got=0 exp=1");
      end
      if (q.size() != 0) begin
         e = q.pop_front();
         total++;
         assert (pc === e.pc) else begin
            bad++;
            $error("FAIL %s pc got=%h exp=%h", e.tag, pc, e.pc);
         end
         total++;
         assert (pc_valid === e.vld) else begin
            bad++;
            $error("FAIL %s pc_valid got=%b exp=%b", e.tag, pc_valid, e.vld);
         end
         total++;
         assert (adel === e.adel) else begin
            bad++;
            $error("FAIL %s adel got=%b exp=%b", e.tag, adel, e.adel);
         end
         total++;
         assert (pend === e.pend) else begin
            bad++;
            $error("FAIL %s pend got=%b exp=%b", e.tag, pend, e.pend);
         end
      end
   endtask

   task automatic drive(input logic st, input logic br,
                        input logic [31:0] bt, input logic jm,
                        input logic [31:0] jt, input logic ex,
                        input logic er, input logic [31:0] et);
      stall       = st;
      br_taken    = br;
      br_target   = bt;
      jmp         = jm;
      jmp_target  = jt;
      exc         = ex;
      eret        = er;
      eret_target = et;
   endtask

   // drive at negedge, expect after the next rising edge
   task automatic step(input logic st, input logic br,
                       input logic [31:0] bt, input logic jm,
                       input logic [31:0] jt, input logic ex,
                       input logic er, input logic [31:0] et,
                       input logic [31:0] e_pc, input logic e_v,
                       input logic e_a, input logic e_p,
                       input string tag);
      @(negedge clk);
      drive(st, br, bt, jm, jt, ex, er, et);
      expect_out(e_pc, e_v, e_a, e_p, tag);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic run1(input logic [31:0] e_pc, input string tag);
      step(0, 0, 0, 0, 0, 0, 0, 0, e_pc, 1, e_pc[1:0] != 2'b00, 0, tag);
   endtask

   initial begin
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      // T1
      repeat (3) @(posedge clk);
      #1;
      expect_out(32'hBFC0_0000, 0, 0, 0, "t1_in_reset");
      check_out();
      @(negedge clk);
      rst = 1'b1;
      #1;
      expect_out(32'hBFC0_0000, 0, 0, 0, "t1_released");
      check_out();
      @(posedge clk);
      #1;
      expect_out(32'hBFC0_0000, 1, 0, 0, "t1_boot_edge");
      check_out();
      run1(32'hBFC0_0004, "t1_first_inc");
      // T2
      run1(32'hBFC0_0008, "t2_inc8");
      run1(32'hBFC0_000C, "t2_incC");
      run1(32'hBFC0_0010, "t2_inc10");
      step(1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0010, 1, 0, 0, "t2_stall1");
      step(1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0010, 1, 0, 0, "t2_stall2");
      // T3
      step(1, 1, 32'hBFC0_0100, 0, 0, 0, 0, 0,
           32'hBFC0_0010, 1, 0, 1, "t3_capture_br");
      step(1, 0, 0, 1, 32'hBFC0_0200, 0, 0, 0,
           32'hBFC0_0010, 1, 0, 1, "t3_drop_jmp");
      step(0, 1, 32'hBFC0_0300, 0, 0, 0, 0, 0,
           32'hBFC0_0100, 1, 0, 0, "t3_release");
      step(0, 0, 0, 1, 32'hBFC0_0500, 0, 0, 0,
           32'hBFC0_0500, 1, 0, 0, "t3_jmp");
      step(0, 1, 32'hBFC0_0600, 0, 0, 0, 0, 0,
           32'hBFC0_0600, 1, 0, 0, "t3_br");
      step(0, 1, 32'hBFC0_0700, 1, 32'hBFC0_0800, 0, 0, 0,
           32'hBFC0_0700, 1, 0, 0, "t3_br_over_jmp");
      // T4
      step(1, 1, 32'hBFC0_0900, 0, 0, 1, 0, 0,
           32'hBFC0_0380, 1, 0, 0, "t4_exc_stall");
      step(0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0040,
           32'hBFC0_0040, 1, 0, 0, "t4_eret");
      step(1, 0, 0, 0, 0, 1, 1, 32'hBFC0_0044,
           32'hBFC0_0380, 1, 0, 0, "t4_exc_over_eret");
      // T5
      step(0, 0, 0, 1, 32'hBFC0_0102, 0, 0, 0,
           32'hBFC0_0102, 1, 1, 0, "t5_mis_jmp");
      run1(32'hBFC0_0106, "t5_mis_inc");
      step(0, 0, 0, 0, 0, 1, 0, 0,
           32'hBFC0_0380, 1, 0, 0, "t5_exc_clr");
      // T6
      step(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC,
           32'hFFFF_FFFC, 1, 0, 0, "t6_eret_top");
      run1(32'h0000_0000, "t6_wrap");
      step(1, 1, 32'h0000_0010, 0, 0, 0, 0, 0,
           32'h0000_0000, 1, 0, 1, "t6_pend_set");
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      expect_out(32'hBFC0_0000, 0, 0, 0, "t6_async_rst");
      check_out();
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      expect_out(32'hBFC0_0000, 1, 0, 0, "t6_reboot");
      check_out();
      run1(32'hBFC0_0004, "t6_pend_lost");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
